// File: rtl/bdd_gen_pkg.sv
// Shared types and constants for the candidate generator and the samplers.
// Holds the FSM state encoding and the 32-bit Galois LFSR definition.
package bdd_gen_pkg;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CHECK,
        SOL,
        DONE,
        FAIL
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] l
    );
        return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/bdd_lfsr32.sv
// 32-bit Galois right-shift LFSR with load and step controls.
// A zero seed would lock the register, so it is replaced by 1.
module bdd_lfsr32
    import bdd_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (seed == '0) ? LFSR_W'(1) : seed;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_W'(1);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bdd_cand_gen.sv
// Candidate-assignment generator: fills a vector from an LFSR, waits for a
// checker verdict, retries up to MAX_TRIES and hands out a satisfying vector.
module bdd_cand_gen
    import bdd_gen_pkg::*;
#(
    parameter int VEC_W     = 64,
    parameter int CHUNK_W   = 16,
    parameter int MAX_TRIES = 1000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    output logic [VEC_W-1:0] cand,
    output logic             cand_valid,
    input  logic             chk_valid,
    input  logic             chk_sat,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic             busy,
    output logic             fail,
    output logic [CNT_W-1:0] tries
);

    localparam int FILL_N = VEC_W / CHUNK_W;
    localparam int FC_W   = $clog2(FILL_N) + 1;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fill_q, fill_d;
    logic [VEC_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  tries_q, tries_d;
    logic              cand_valid_q, cand_valid_d;
    logic              sol_valid_q, sol_valid_d;
    logic              busy_q, busy_d;
    logic              fail_q, fail_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_q;
    logic [VEC_W-1:0]  chunk_ext;
    logic [CNT_W-1:0]  tries_inc;

    bdd_lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    generate
        if (CHUNK_W < LFSR_W) begin : g_unused
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:CHUNK_W];
        end
    endgenerate

    assign chunk_ext = VEC_W'(lfsr_q[CHUNK_W-1:0]);
    assign tries_inc = tries_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        cand_d    = cand_q;
        tries_d   = tries_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_d   = FILL;
                    fill_d    = '0;
                    tries_d   = '0;
                    lfsr_load = 1'b1;
                end
            end
            FILL: begin
                // New chunk enters at the top, so the first chunk ends lowest.
                lfsr_step = 1'b1;
                cand_d = (cand_q >> CHUNK_W)
                       | (chunk_ext << (VEC_W - CHUNK_W));
                if (fill_q == FC_W'(FILL_N - 1)) begin
                    state_d = CHECK;
                end else begin
                    fill_d = fill_q + FC_W'(1);
                end
            end
            CHECK: begin
                if (chk_valid) begin
                    tries_d = tries_inc;
                    if (chk_sat) begin
                        state_d = SOL;
                    end else if (tries_inc == CNT_W'(MAX_TRIES)) begin
                        state_d = FAIL;
                    end else begin
                        state_d = FILL;
                        fill_d  = '0;
                    end
                end
            end
            SOL: begin
                if (sol_ready) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cand_valid_d = (state_d == CHECK);
        sol_valid_d  = (state_d == SOL);
        busy_d       = (state_d == FILL) || (state_d == CHECK)
                    || (state_d == SOL);
        fail_d       = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            cand_q       <= '0;
            tries_q      <= '0;
            cand_valid_q <= 1'b0;
            sol_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            cand_q       <= cand_d;
            tries_q      <= tries_d;
            cand_valid_q <= cand_valid_d;
            sol_valid_q  <= sol_valid_d;
            busy_q       <= busy_d;
            fail_q       <= fail_d;
        end
    end

    assign cand       = cand_q;
    assign cand_valid = cand_valid_q;
    assign sol_valid  = sol_valid_q;
    assign busy       = busy_q;
    assign fail       = fail_q;
    assign tries      = tries_q;

endmodule
